// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// Receives PS/2 device-to-host frames from the raw keyboard pins. Each frame
// has a start bit, 8 data bits sent LSB first, an odd parity bit and a stop bit.
// The E0 (extended) and F0 (break) prefix bytes are folded into flags. One
// scancode is presented per key event, with a single-cycle valid strobe.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_dat     raw PS/2 data pin (asynchronous)
//   code        decoded scancode, qualified by code_valid, held until next event
//   code_valid  one-cycle pulse per decoded key event
//   extended    event was E0-prefixed, qualified by code_valid
//   is_release  event was F0-prefixed (break), qualified by code_valid
//   last_code   code of the most recent event, for the HEX display
//   parity_err  one-cycle pulse on an odd-parity failure
//   frame_err   one-cycle pulse on a bad start bit, bad stop bit or timeout
//   busy        high while a frame is in progress
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | waiting for the start bit
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit and parity, then decoding the byte
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       extended,
  output logic       is_release,
  output logic [7:0] last_code,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fe;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d;
  logic          rel_pend_q, rel_pend_d;
  logic [7:0]    code_d, last_d;
  logic          ext_d, rel_d;
  logic          valid_d, perr_d, ferr_d;
  logic          timeout;

  // Sync flops and edge history reset to 1, which is the idle bus level.
  // Releasing reset therefore cannot create a false falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fe    = clk_prev & ~clk_s;

  // A falling edge in the same cycle takes priority over the timeout.
  assign timeout = (state_q != S_IDLE) && !fe && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    par_d      = par_q;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    code_d     = code;
    last_d     = last_code;
    ext_d      = extended;
    rel_d      = is_release;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    tmo_d      = (state_q == S_IDLE || fe) ? '0 : tmo_q + TW'(1);

    if (timeout) begin
      state_d    = S_IDLE;
      ferr_d     = 1'b1;
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (fe) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dat_s) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!dat_s) begin
            ferr_d     = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end else if ((^shift_q ^ par_q) == 1'b0) begin
            perr_d     = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            rel_pend_d = 1'b1;
          end else begin
            code_d     = shift_q;
            last_d     = shift_q;
            ext_d      = ext_pend_q;
            rel_d      = rel_pend_q;
            valid_d    = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      code       <= '0;
      last_code  <= '0;
      extended   <= 1'b0;
      is_release <= 1'b0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      code       <= code_d;
      last_code  <= last_d;
      extended   <= ext_d;
      is_release <= rel_d;
      code_valid <= valid_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed frames plus randomized frames. The
// results are checked against a byte-level model of the prefix and error rules.
module tb_ps2_scancode_rx;

  localparam int TMO  = 200;
  localparam int SYNC = 2;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_dat;
  logic [7:0] code, last_code;
  logic       code_valid, extended, is_release, parity_err, frame_err, busy;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .code(code), .code_valid(code_valid), .extended(extended),
    .is_release(is_release), .last_code(last_code), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0;
  int cyc = 0, t_stop = 0, t_valid = 0;
  int vcnt = 0, pcnt = 0, fcnt = 0, overlap = 0;

  // reference model state
  logic       ext_p = 1'b0, rel_p = 1'b0;
  logic [7:0] m_code = 8'h00, m_last = 8'h00;
  logic       m_ext = 1'b0, m_rel = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin
      vcnt++;
      t_valid = cyc;
    end
    if (parity_err) pcnt++;
    if (frame_err) fcnt++;
    if (code_valid && (parity_err || frame_err)) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit is_stop);
    ps2_dat = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    if (is_stop) t_stop = cyc;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 0);
    send_bit((~^b) ^ bad_par, 0);
    send_bit(~bad_stop, 1);
    ps2_dat = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":code"}, code, m_code);
    chk({tag, ":ext"}, extended, m_ext);
    chk({tag, ":rel"}, is_release, m_rel);
    chk({tag, ":last"}, last_code, m_last);
    chk({tag, ":busy"}, busy, 1'b0);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b,
                             input bit bad_par, input bit bad_stop);
    int v0, p0, f0, ev, ep, ef;
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    ev = 0; ep = 0; ef = 0;
    if (bad_stop) begin
      ef = 1; ext_p = 1'b0; rel_p = 1'b0;
    end else if (bad_par) begin
      ep = 1; ext_p = 1'b0; rel_p = 1'b0;
    end else if (b == 8'hE0) begin
      ext_p = 1'b1;
    end else if (b == 8'hF0) begin
      rel_p = 1'b1;
    end else begin
      ev = 1; m_code = b; m_last = b; m_ext = ext_p; m_rel = rel_p;
      ext_p = 1'b0; rel_p = 1'b0;
    end
    send_frame(b, bad_par, bad_stop);
    wait_clk(10);
    chk({tag, ":valid_n"}, vcnt - v0, ev);
    chk({tag, ":perr_n"}, pcnt - p0, ep);
    chk({tag, ":ferr_n"}, fcnt - f0, ef);
    if (ev == 1) chk({tag, ":latency"}, t_valid - t_stop, SYNC + 1);
    check_outputs(tag);
  endtask

  initial begin
    int f0, v0, p0;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    wait_clk(5);
    chk("rst:code_valid", code_valid, 1'b0);
    chk("rst:perr", parity_err, 1'b0);
    chk("rst:ferr", frame_err, 1'b0);
    check_outputs("rst");
    reset = 1'b0;
    wait_clk(5);

    frame_check("t1", 8'h1C, 0, 0);
    frame_check("t2a", 8'hF0, 0, 0);
    frame_check("t2b", 8'h1C, 0, 0);
    frame_check("t2c", 8'h1C, 0, 0);
    frame_check("t3a", 8'hE0, 0, 0);
    frame_check("t3b", 8'hF0, 0, 0);
    frame_check("t3c", 8'h75, 0, 0);
    frame_check("t4a", 8'hF0, 0, 0);
    frame_check("t4b", 8'h1C, 1, 0);
    frame_check("t4c", 8'h1C, 0, 0);
    frame_check("e1", 8'hE1, 0, 0);

    // timeout: start + 4 data bits, then the clock stays high
    f0 = fcnt; v0 = vcnt;
    frame_check("t5pre", 8'hE0, 0, 0);
    f0 = fcnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 0);
    wait_clk(TMO + 10);
    ext_p = 1'b0; rel_p = 1'b0;
    chk("t5:ferr_n", fcnt - f0, 1);
    chk("t5:busy", busy, 1'b0);
    frame_check("t5b", 8'h29, 0, 0);

    // start bit seen as 1 while idle
    f0 = fcnt;
    send_bit(1'b1, 0);
    wait_clk(10);
    chk("idle1:ferr_n", fcnt - f0, 1);
    chk("idle1:busy", busy, 1'b0);

    // reset after 6 bits of a frame
    f0 = fcnt; v0 = vcnt; p0 = pcnt;
    frame_check("t6pre", 8'hF0, 0, 0);
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    ext_p = 1'b0; rel_p = 1'b0;
    m_code = 8'h00; m_last = 8'h00; m_ext = 1'b0; m_rel = 1'b0;
    wait_clk(5);
    chk("t6:valid_n", vcnt - v0, 0);
    chk("t6:perr_n", pcnt - p0, 0);
    chk("t6:ferr_n", fcnt - f0, 0);
    check_outputs("t6rst");
    frame_check("t6b", 8'h5A, 0, 0);
    frame_check("t6c", 8'h33, 0, 1);

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      int sel, err;
      sel = $urandom_range(0, 9);
      err = $urandom_range(0, 9);
      b = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom);
      frame_check($sformatf("rnd%0d", k), b, err == 0, err == 1);
    end

    chk("no_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
